// File: rtl/vga_pattern_sequencer.sv
// vga_pattern_sequencer: turns debounced switch presses and an auto-cycle timer
// into a pattern index. Changes are staged in a target register and committed
// to o_Pattern only on a frame start, so a frame never tears.
// Optional build macro: VGA_SEQ_BLANK_EN adds a one-frame black-out before
// each commit.
//
// state   | meaning
// --------+-----------------------------------------------------------
// IDLE    | nothing staged; o_Pattern equals the committed target
// PENDING | target differs from (or re-requests) o_Pattern, awaiting frame start
// APPLY   | o_Pattern just changed; o_Update pulses for this one cycle
// BLANK   | (macro only) screen forced black for one frame before the commit
module vga_pattern_sequencer #(
  parameter int NUM_PATTERNS = 8,
  parameter int PAT_W        = 3,
  parameter int AUTO_FRAMES  = 60,
  parameter int FCNT_W       = 8
) (
  input  logic             CLK,
  input  logic             RST_N,
  input  logic             i_SW1,
  input  logic             i_SW2,
  input  logic             i_SW3,
  input  logic             i_SW4,
  input  logic             i_Frame_Start,
  output logic [PAT_W-1:0] o_Pattern,
  output logic             o_Update,
  output logic             o_Pending,
  output logic             o_Auto,
  output logic             o_Blank
);

  typedef enum logic [1:0] {
    S_IDLE,
    S_PENDING,
    S_APPLY
`ifdef VGA_SEQ_BLANK_EN
    , S_BLANK
`endif
  } state_t;

  localparam logic [PAT_W-1:0]  PAT_LAST = PAT_W'(NUM_PATTERNS - 1);
  localparam logic [FCNT_W-1:0] CNT_LAST = FCNT_W'(AUTO_FRAMES - 1);

  state_t            state, state_nxt;
  logic [3:0]        sw_prev;
  logic [3:0]        sw_now;
  logic [3:0]        press;
  logic              man_zero, man_next, man_prev, man_any;
  logic              auto_tick, accept, commit, restage;
  logic [PAT_W-1:0]  r_target, target_inc, target_dec, target_nxt;
  logic [FCNT_W-1:0] frame_cnt;

  assign sw_now   = {i_SW4, i_SW3, i_SW2, i_SW1};
  assign press    = sw_now & ~sw_prev;
  // SW3 overrides next/prev; next and prev together cancel out.
  assign man_zero = press[2];
  assign man_next = press[0] & ~press[1] & ~press[2];
  assign man_prev = press[1] & ~press[0] & ~press[2];
  assign man_any  = man_zero | man_next | man_prev;

  assign auto_tick = o_Auto & i_Frame_Start & (frame_cnt == CNT_LAST);
  assign accept    = man_any | auto_tick;

  assign target_inc = (r_target == PAT_LAST) ? '0 : r_target + 1'b1;
  assign target_dec = (r_target == '0) ? PAT_LAST : r_target - 1'b1;

  // Target selection: manual presses win over the internal auto step.
  always_comb begin
    target_nxt = r_target;
    if (man_zero)       target_nxt = '0;
    else if (man_next)  target_nxt = target_inc;
    else if (man_prev)  target_nxt = target_dec;
    else if (auto_tick) target_nxt = target_inc;
  end

  // Next-state and output decode. restage remembers a press that landed in
  // the commit cycle so APPLY keeps the change pending for the next frame.
  always_comb begin
    state_nxt = state;
    commit    = 1'b0;
    o_Update  = 1'b0;
    o_Pending = 1'b0;
    o_Blank   = 1'b0;
    case (state)
      S_IDLE: begin
        if (accept) state_nxt = S_PENDING;
      end
      S_PENDING: begin
        o_Pending = 1'b1;
        if (i_Frame_Start) begin
`ifdef VGA_SEQ_BLANK_EN
          state_nxt = S_BLANK;
`else
          commit    = 1'b1;
          state_nxt = S_APPLY;
`endif
        end
      end
      S_APPLY: begin
        o_Update  = 1'b1;
        o_Pending = accept | restage;
        state_nxt = (accept | restage) ? S_PENDING : S_IDLE;
      end
`ifdef VGA_SEQ_BLANK_EN
      S_BLANK: begin
        o_Pending = 1'b1;
        o_Blank   = 1'b1;
        if (i_Frame_Start) begin
          commit    = 1'b1;
          state_nxt = S_APPLY;
        end
      end
`endif
      default: state_nxt = S_IDLE;
    endcase
  end

  // State, edge history, target, committed pattern and restage flag.
  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      state     <= S_IDLE;
      sw_prev   <= '0;
      r_target  <= '0;
      o_Pattern <= '0;
      restage   <= 1'b0;
    end else begin
      state    <= state_nxt;
      sw_prev  <= sw_now;
      r_target <= target_nxt;
      restage  <= commit & accept;
      if (commit) o_Pattern <= r_target;
    end
  end

  // Auto mode flag and frame counter; any toggle or manual press restarts the count.
  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      o_Auto    <= 1'b0;
      frame_cnt <= '0;
    end else begin
      if (press[3]) o_Auto <= ~o_Auto;
      if (press[3] | man_any)
        frame_cnt <= '0;
      else if (o_Auto & i_Frame_Start)
        frame_cnt <= (frame_cnt == CNT_LAST) ? '0 : frame_cnt + 1'b1;
    end
  end

endmodule

// File: tb/tb_vga_pattern_sequencer.sv
// Testbench for vga_pattern_sequencer: directed scenarios plus randomized
// switch/frame traffic, checked through a scoreboard fed by a reference model.
module tb_vga_pattern_sequencer;

  localparam int NP = 8;
  localparam int PW = 3;
  localparam int AF = 3;
  localparam int FW = 8;

  logic          CLK = 1'b0;
  logic          RST_N = 1'b0;
  logic          i_SW1 = 1'b0, i_SW2 = 1'b0, i_SW3 = 1'b0, i_SW4 = 1'b0;
  logic          i_Frame_Start = 1'b0;
  logic [PW-1:0] o_Pattern;
  logic          o_Update, o_Pending, o_Auto, o_Blank;

  vga_pattern_sequencer #(
    .NUM_PATTERNS(NP), .PAT_W(PW), .AUTO_FRAMES(AF), .FCNT_W(FW)
  ) dut (
    .CLK(CLK), .RST_N(RST_N),
    .i_SW1(i_SW1), .i_SW2(i_SW2), .i_SW3(i_SW3), .i_SW4(i_SW4),
    .i_Frame_Start(i_Frame_Start),
    .o_Pattern(o_Pattern), .o_Update(o_Update), .o_Pending(o_Pending),
    .o_Auto(o_Auto), .o_Blank(o_Blank)
  );

  always #5 CLK = ~CLK;

  int n_checks = 0;
  int n_fail   = 0;
  int n_commit = 0;
  int n_update = 0;
  int exp_q[$];

  function automatic void chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d, expected %0d", name, act, exp);
    end
  endfunction

  // Reference model: tracks staged/committed patterns from the behavioural rules.
  int         m_target, m_auto, m_cnt, m_staged, m_blanking;
  logic [3:0] m_prev, m_lvl, m_p;
  bit         m_man, m_tick, m_pr;

  initial begin
    forever begin
      @(posedge CLK or negedge RST_N);
      if (!RST_N) begin
        m_target = 0; m_auto = 0; m_cnt = 0; m_staged = 0; m_blanking = 0;
        m_prev = '0;
        exp_q.delete();
      end else begin
        m_lvl  = {i_SW4, i_SW3, i_SW2, i_SW1};
        m_p    = m_lvl & ~m_prev;
        m_prev = m_lvl;
        m_man  = m_p[2] || (m_p[0] != m_p[1]);
        m_tick = (m_auto != 0) && i_Frame_Start && (m_cnt == AF - 1);
        m_pr   = m_man || m_tick;
        if (i_Frame_Start) begin
`ifdef VGA_SEQ_BLANK_EN
          if (m_blanking != 0) begin
            exp_q.push_back(m_target); n_commit++;
            m_blanking = 0; m_staged = int'(m_pr);
          end else if (m_staged != 0) begin
            m_blanking = 1; m_staged = 0;
          end else begin
            m_staged = int'(m_pr);
          end
`else
          if (m_staged != 0) begin
            exp_q.push_back(m_target); n_commit++;
          end
          m_staged = int'(m_pr);
`endif
        end else if (m_blanking == 0) begin
          m_staged = int'((m_staged != 0) || m_pr);
        end
        if (m_p[2])                m_target = 0;
        else if (m_p[0] && !m_p[1]) m_target = (m_target + 1) % NP;
        else if (m_p[1] && !m_p[0]) m_target = (m_target + NP - 1) % NP;
        else if (m_tick)            m_target = (m_target + 1) % NP;
        if (m_p[3] || m_man) m_cnt = 0;
        else if ((m_auto != 0) && i_Frame_Start) m_cnt = (m_cnt == AF - 1) ? 0 : m_cnt + 1;
        if (m_p[3]) m_auto = (m_auto != 0) ? 0 : 1;
      end
    end
  end

  // Monitor: pops the scoreboard on every update pulse, checks mode flags.
  initial begin
    forever begin
      @(negedge CLK);
      if (RST_N) begin
        chk("auto flag", o_Auto, m_auto);
        chk("blank flag", o_Blank, m_blanking);
        if (o_Update === 1'b1) begin
          n_update++;
          if (exp_q.size() == 0) begin
            n_checks++; n_fail++;
            $display("FAIL unexpected update: pattern %0d, expected no update", o_Pattern);
          end else begin
            chk("committed pattern", o_Pattern, exp_q.pop_front());
          end
        end
      end
    end
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog: time limit reached, expected test end");
    $fatal(1, "timeout");
  end

  task automatic step(input logic [3:0] sw, input logic fs);
    {i_SW4, i_SW3, i_SW2, i_SW1} = sw;
    i_Frame_Start = fs;
    @(posedge CLK);
    #1;
  endtask

  task automatic idle(input int n);
    repeat (n) step({i_SW4, i_SW3, i_SW2, i_SW1}, 1'b0);
  endtask

  task automatic press(input int k);
    logic [3:0] s;
    s = {i_SW4, i_SW3, i_SW2, i_SW1};
    s[k] = 1'b1;
    step(s, 1'b0);
    s[k] = 1'b0;
    step(s, 1'b0);
  endtask

  task automatic frame();
    step({i_SW4, i_SW3, i_SW2, i_SW1}, 1'b1);
  endtask

  task automatic commit_frames();
`ifdef VGA_SEQ_BLANK_EN
    frame();
    idle(4);
`endif
    frame();
  endtask

  int u0;

  initial begin
    // Reset state
    #23;
    chk("reset pattern", o_Pattern, 0);
    chk("reset update", o_Update, 0);
    chk("reset pending", o_Pending, 0);
    chk("reset auto", o_Auto, 0);
    chk("reset blank", o_Blank, 0);
    @(negedge CLK);
    RST_N = 1'b1;
    @(posedge CLK); #1;
    idle(2);

    // T2 accumulate within one frame
    u0 = n_update;
    press(0); press(0); press(0); press(1);
    chk("T2 pending", o_Pending, 1);
    commit_frames();
    chk("T2 pattern", o_Pattern, 2);
    chk("T2 update", o_Update, 1);
    idle(1);
    chk("T2 update drop", o_Update, 0);
    chk("T2 pending clear", o_Pending, 0);
    idle(3);
    chk("T2 pulse count", n_update - u0, 1);

    // T3 wrap and ignored next+prev
    press(2); commit_frames(); idle(3);
    chk("T3 zero", o_Pattern, 0);
    press(1); commit_frames();
    chk("T3 wrap down", o_Pattern, 7);
    idle(3);
    press(0); commit_frames();
    chk("T3 wrap up", o_Pattern, 0);
    idle(3);
    step(4'b0011, 1'b0);
    chk("T3 both pending", o_Pending, 0);
    step(4'b0000, 1'b0);
    idle(2);
    frame();
    chk("T3 both update", o_Update, 0);
    chk("T3 both pattern", o_Pattern, 0);
    idle(3);

`ifndef VGA_SEQ_BLANK_EN
    // T4 press colliding with frame start in IDLE, then in PENDING
    press(0); press(0); frame(); idle(3);
    step(4'b0001, 1'b1);
    chk("T4 idle collide update", o_Update, 0);
    chk("T4 idle collide pattern", o_Pattern, 2);
    chk("T4 idle collide pending", o_Pending, 1);
    step(4'b0000, 1'b0); idle(3);
    frame();
    chk("T4 later pattern", o_Pattern, 3);
    chk("T4 later update", o_Update, 1);
    idle(3);
    press(0);
    step(4'b0001, 1'b1);
    chk("T4 pending collide pattern", o_Pattern, 4);
    chk("T4 pending collide restage", o_Pending, 1);
    step(4'b0000, 1'b0); idle(3);
    frame();
    chk("T4 restaged pattern", o_Pattern, 5);
    idle(3);
`endif

    // T1 reset mid-PENDING with target 4
    press(2); press(0); press(0); press(0); press(0);
    chk("T1 pending before reset", o_Pending, 1);
    #2 RST_N = 1'b0;
    #1;
    chk("T1 async pattern", o_Pattern, 0);
    chk("T1 async pending", o_Pending, 0);
    chk("T1 async update", o_Update, 0);
    @(posedge CLK); #2 RST_N = 1'b1;
    idle(2);
    u0 = n_update;
    frame(); idle(3);
    chk("T1 no update", n_update - u0, 0);
    chk("T1 pattern", o_Pattern, 0);

`ifndef VGA_SEQ_BLANK_EN
    // T5 auto mode with AUTO_FRAMES = 3
    press(3);
    chk("T5 auto on", o_Auto, 1);
    repeat (3) begin frame(); idle(3); end
    chk("T5 before first step", o_Pattern, 0);
    frame();
    chk("T5 first step", o_Pattern, 1);
    idle(3);
    repeat (2) begin frame(); idle(3); end
    frame();
    chk("T5 second step", o_Pattern, 2);
    idle(3);
    press(2);
    frame(); idle(3);
    chk("T5 sw3 pattern", o_Pattern, 0);
    repeat (2) begin frame(); idle(3); end
    chk("T5 restart hold", o_Pattern, 0);
    frame();
    chk("T5 restart step", o_Pattern, 1);
    idle(3);
    press(3);
    chk("T5 auto off", o_Auto, 0);
`else
    // T6 blanking frame before the commit
    press(0);
    frame();
    chk("T6 blank on", o_Blank, 1);
    chk("T6 pattern held", o_Pattern, 0);
    idle(6);
    chk("T6 blank held", o_Blank, 1);
    frame();
    chk("T6 pattern", o_Pattern, 1);
    chk("T6 blank off", o_Blank, 0);
    chk("T6 update", o_Update, 1);
`endif
    idle(3);

    // Randomized traffic
    for (int f = 0; f < 150; f++) begin
      int len;
      len = $urandom_range(8, 20);
      for (int c = 0; c < len; c++) begin
        logic [3:0] sw;
        sw = {i_SW4, i_SW3, i_SW2, i_SW1};
        if ($urandom_range(0, 5) == 0) sw[$urandom_range(0, 2)] = ~sw[$urandom_range(0, 2)];
        if ($urandom_range(0, 5) == 0) sw[$urandom_range(0, 2)] = 1'b0;
        if ($urandom_range(0, 60) == 0) sw[3] = ~sw[3];
        step(sw, (c == 0));
      end
    end
    step(4'b0000, 1'b0);
    idle(10);

    chk("scoreboard drained", exp_q.size(), 0);
    chk("update count", n_update, n_commit);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
